// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, combinational reads,
// x0 hardwired to zero, optional same-cycle write bypass and a busy scoreboard.
module regfile_mp #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH),
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr0_en,
  input  logic [AW-1:0]       wr0_addr,
  input  logic [XLEN-1:0]     wr0_data,
  input  logic                wr1_en,
  input  logic [AW-1:0]       wr1_addr,
  input  logic [XLEN-1:0]     wr1_data,
  input  logic                bs_en,
  input  logic [AW-1:0]       bs_addr,
  output logic [DEPTH-1:0]    busy_vec
);

  localparam bit BYP = (BYPASS != 0);

  logic [XLEN-1:0]  mem_reg [DEPTH];
  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;

  // wr1 is assigned last so it wins a same-address collision; entry 0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      busy_reg <= '0;
    end else begin
      if (wr0_en && (wr0_addr != '0)) begin
        mem_reg[wr0_addr] <= wr0_data;
      end
      if (wr1_en && (wr1_addr != '0)) begin
        mem_reg[wr1_addr] <= wr1_data;
      end
      busy_reg <= busy_next;
    end
  end

  assign busy_next[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_busy
      logic set_hit;
      logic clr_hit;
      assign set_hit = bs_en && (bs_addr == AW'(gi));
      assign clr_hit = (wr0_en && (wr0_addr == AW'(gi))) ||
                       (wr1_en && (wr1_addr == AW'(gi)));
      // A newly issued producer outranks the retiring one.
      assign busy_next[gi] = set_hit ? 1'b1 : (clr_hit ? 1'b0 : busy_reg[gi]);
    end

    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] addr;
      logic          hit0;
      logic          hit1;
      logic          set_hit;
      assign addr    = rd_addr[gi*AW +: AW];
      // Bypass is suppressed during reset so outputs stay zero while rst is held.
      assign hit0    = BYP && !rst && (addr != '0) && wr0_en && (wr0_addr == addr);
      assign hit1    = BYP && !rst && (addr != '0) && wr1_en && (wr1_addr == addr);
      assign set_hit = bs_en && (bs_addr == addr);
      assign rd_data[gi*XLEN +: XLEN] = hit1 ? wr1_data :
                                        (hit0 ? wr0_data : mem_reg[addr]);
      assign rd_busy[gi] = ((hit0 || hit1) && !set_hit) ? 1'b0 : busy_reg[addr];
    end
  endgenerate

  assign busy_vec = busy_reg;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypass and non-bypass builds side by side,
// plus a wide four-read-port build.
module tb_regfile_mp;

  logic clk;
  logic rst;

  logic [9:0]  rd_addr;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0]  rd_busy_b, rd_busy_n;
  logic        wr0_en, wr1_en, bs_en;
  logic [4:0]  wr0_addr, wr1_addr, bs_addr;
  logic [31:0] wr0_data, wr1_data;
  logic [31:0] busy_vec_b, busy_vec_n;

  logic [15:0]  w_rd_addr;
  logic [255:0] w_rd_data;
  logic [3:0]   w_rd_busy;
  logic         w_wr0_en, w_wr1_en, w_bs_en;
  logic [3:0]   w_wr0_addr, w_wr1_addr, w_bs_addr;
  logic [63:0]  w_wr0_data, w_wr1_data;
  logic [15:0]  w_busy_vec;

  int vec_cnt = 0;
  int err_cnt = 0;

  regfile_mp #(.BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .bs_en(bs_en), .bs_addr(bs_addr), .busy_vec(busy_vec_b)
  );

  regfile_mp #(.BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .bs_en(bs_en), .bs_addr(bs_addr), .busy_vec(busy_vec_n)
  );

  regfile_mp #(.XLEN(64), .DEPTH(16), .NRD(4), .BYPASS(1)) u_wide (
    .clk(clk), .rst(rst), .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
    .wr0_en(w_wr0_en), .wr0_addr(w_wr0_addr), .wr0_data(w_wr0_data),
    .wr1_en(w_wr1_en), .wr1_addr(w_wr1_addr), .wr1_data(w_wr1_data),
    .bs_en(w_bs_en), .bs_addr(w_bs_addr), .busy_vec(w_busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr0_en = 0; wr1_en = 0; bs_en = 0;
    w_wr0_en = 0; w_wr1_en = 0; w_bs_en = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rd_addr = '0; wr0_addr = '0; wr1_addr = '0; bs_addr = '0;
    wr0_data = '0; wr1_data = '0;
    w_rd_addr = '0; w_wr0_addr = '0; w_wr1_addr = '0; w_bs_addr = '0;
    w_wr0_data = '0; w_wr1_data = '0;
    idle_inputs();
    #1 rst = 1'b1;
    #2;
    vec_cnt++;
    if (busy_vec_b !== 32'h0 || busy_vec_n !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_busy: byp=%h nobyp=%h expected 0", busy_vec_b, busy_vec_n);
    end
    step();
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      vec_cnt++;
      if (rd_data_b !== 64'h0 || rd_data_n !== 64'h0 || rd_busy_b !== 2'b0) begin
        err_cnt++;
        $display("FAIL reset_read a=%0d: byp=%h nobyp=%h busy=%b expected 0", a, rd_data_b, rd_data_n, rd_busy_b);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_bypass();
    step();
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
    rd_addr = {5'd0, 5'd5};
    #1;
    vec_cnt++;
    if (rd_data_b[31:0] !== 32'hDEADBEEF) begin
      err_cnt++;
      $display("FAIL bypass_same_cycle: got %h expected deadbeef", rd_data_b[31:0]);
    end
    vec_cnt++;
    if (rd_data_n[31:0] !== 32'h0) begin
      err_cnt++;
      $display("FAIL nobypass_same_cycle: got %h expected 0", rd_data_n[31:0]);
    end
    step();
    idle_inputs();
    #1;
    vec_cnt++;
    if (rd_data_n[31:0] !== 32'hDEADBEEF || rd_data_b[31:0] !== 32'hDEADBEEF) begin
      err_cnt++;
      $display("FAIL write_next_cycle: byp=%h nobyp=%h expected deadbeef", rd_data_b[31:0], rd_data_n[31:0]);
    end
    $display("test_bypass done");
  endtask

  task automatic test_x0_collision();
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'h12345678;
    wr1_en = 1; wr1_addr = 0; wr1_data = 32'h12345678;
    rd_addr = {5'd0, 5'd0};
    #1;
    vec_cnt++;
    if (rd_data_b !== 64'h0 || rd_data_n !== 64'h0) begin
      err_cnt++;
      $display("FAIL x0_same_cycle: byp=%h nobyp=%h expected 0", rd_data_b, rd_data_n);
    end
    step();
    idle_inputs();
    #1;
    vec_cnt++;
    if (rd_data_b !== 64'h0 || rd_data_n !== 64'h0) begin
      err_cnt++;
      $display("FAIL x0_after_write: byp=%h nobyp=%h expected 0", rd_data_b, rd_data_n);
    end
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'h11;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h22;
    rd_addr = {5'd0, 5'd7};
    #1;
    vec_cnt++;
    if (rd_data_b[31:0] !== 32'h22) begin
      err_cnt++;
      $display("FAIL collision_bypass: got %h expected 22", rd_data_b[31:0]);
    end
    step();
    idle_inputs();
    #1;
    vec_cnt++;
    if (rd_data_b[31:0] !== 32'h22 || rd_data_n[31:0] !== 32'h22) begin
      err_cnt++;
      $display("FAIL collision_stored: byp=%h nobyp=%h expected 22", rd_data_b[31:0], rd_data_n[31:0]);
    end
    $display("test_x0_collision done");
  endtask

  task automatic test_scoreboard();
    bs_en = 1; bs_addr = 9;
    step();
    idle_inputs();
    rd_addr = {5'd9, 5'd0};
    #1;
    vec_cnt++;
    if (busy_vec_b !== 32'h200 || busy_vec_n !== 32'h200) begin
      err_cnt++;
      $display("FAIL busy_set: byp=%h nobyp=%h expected 00000200", busy_vec_b, busy_vec_n);
    end
    vec_cnt++;
    if (rd_busy_b !== 2'b10 || rd_busy_n !== 2'b10) begin
      err_cnt++;
      $display("FAIL rd_busy_set: byp=%b nobyp=%b expected 10", rd_busy_b, rd_busy_n);
    end
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'h55;
    #1;
    vec_cnt++;
    if (rd_busy_b !== 2'b00 || rd_busy_n !== 2'b10) begin
      err_cnt++;
      $display("FAIL rd_busy_clear_same_cycle: byp=%b nobyp=%b expected 00/10", rd_busy_b, rd_busy_n);
    end
    step();
    idle_inputs();
    #1;
    vec_cnt++;
    if (busy_vec_b !== 32'h0 || rd_data_b[63:32] !== 32'h55 || rd_data_n[63:32] !== 32'h55) begin
      err_cnt++;
      $display("FAIL busy_clear: busy=%h byp=%h nobyp=%h expected 0/55/55", busy_vec_b, rd_data_b[63:32], rd_data_n[63:32]);
    end
    bs_en = 1; bs_addr = 9;
    wr1_en = 1; wr1_addr = 9; wr1_data = 32'h66;
    step();
    idle_inputs();
    #1;
    vec_cnt++;
    if (busy_vec_b !== 32'h200 || rd_data_b[63:32] !== 32'h66) begin
      err_cnt++;
      $display("FAIL set_beats_clear: busy=%h data=%h expected 00000200/66", busy_vec_b, rd_data_b[63:32]);
    end
    bs_en = 1; bs_addr = 0;
    step();
    idle_inputs();
    #1;
    vec_cnt++;
    if (busy_vec_b !== 32'h200) begin
      err_cnt++;
      $display("FAIL busy_x0_ignored: got %h expected 00000200", busy_vec_b);
    end
    $display("test_scoreboard done");
  endtask

  task automatic test_async_reset();
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'hA5A5A5A5;
    bs_en = 1; bs_addr = 3;
    step();
    idle_inputs();
    rd_addr = {5'd0, 5'd3};
    #1;
    vec_cnt++;
    if (rd_data_b[31:0] !== 32'hA5A5A5A5 || busy_vec_b !== 32'h208) begin
      err_cnt++;
      $display("FAIL pre_reset_state: data=%h busy=%h expected a5a5a5a5/00000208", rd_data_b[31:0], busy_vec_b);
    end
    #1 rst = 1'b1;
    #1;
    vec_cnt++;
    if (rd_data_b[31:0] !== 32'h0 || busy_vec_b !== 32'h0 || busy_vec_n !== 32'h0) begin
      err_cnt++;
      $display("FAIL async_reset: data=%h busy=%h/%h expected 0", rd_data_b[31:0], busy_vec_b, busy_vec_n);
    end
    wr0_en = 1; wr0_addr = 4; wr0_data = 32'hCAFEF00D;
    bs_en = 1; bs_addr = 4;
    rd_addr = {5'd4, 5'd4};
    #1;
    vec_cnt++;
    if (rd_data_b !== 64'h0) begin
      err_cnt++;
      $display("FAIL reset_no_bypass: got %h expected 0", rd_data_b);
    end
    step();
    idle_inputs();
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (rd_data_b !== 64'h0 || rd_data_n !== 64'h0 || busy_vec_b !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_drops_write: byp=%h nobyp=%h busy=%h expected 0", rd_data_b, rd_data_n, busy_vec_b);
    end
    $display("test_async_reset done");
  endtask

  task automatic test_wide();
    logic [63:0] exp_val [4];
    exp_val[0] = 64'h1111_2222_3333_4444;
    exp_val[1] = 64'h5555_6666_7777_8888;
    exp_val[2] = 64'h9999_AAAA_BBBB_CCCC;
    exp_val[3] = 64'hDDDD_EEEE_FFFF_0001;
    w_wr0_en = 1; w_wr0_addr = 1; w_wr0_data = exp_val[0];
    w_wr1_en = 1; w_wr1_addr = 2; w_wr1_data = exp_val[1];
    step();
    w_wr0_addr = 3; w_wr0_data = exp_val[2];
    w_wr1_addr = 4; w_wr1_data = exp_val[3];
    step();
    idle_inputs();
    w_rd_addr = {4'd4, 4'd3, 4'd2, 4'd1};
    #1;
    for (int k = 0; k < 4; k++) begin
      vec_cnt++;
      if (w_rd_data[k*64 +: 64] !== exp_val[k]) begin
        err_cnt++;
        $display("FAIL wide_port%0d: got %h expected %h", k, w_rd_data[k*64 +: 64], exp_val[k]);
      end
    end
    vec_cnt++;
    if (w_busy_vec !== 16'h0 || w_rd_busy !== 4'h0) begin
      err_cnt++;
      $display("FAIL wide_busy: vec=%h rd=%b expected 0", w_busy_vec, w_rd_busy);
    end
    $display("test_wide done");
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_x0_collision();
    test_scoreboard();
    test_async_reset();
    test_wide();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the RISC-V CPU datapath, successor to the single-write register file.
- Synchronous writes, combinational reads, location 0 hardwired to zero.
- Optional write-to-read bypass for same-cycle forwarding.
- Per-register busy scoreboard so the pipeline can stall on pending producers.

Parameters:
- XLEN, 32, register width in bits
- DEPTH, 32, number of registers (power of two, >=2)
- AW, $clog2(DEPTH), address width (derived; do not override)
- NRD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns the stored value only

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- rd_addr  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN]
- rd_busy  out  NRD  busy bit of the register addressed by port k
- wr0_en  in  1  write port 0 enable
- wr0_addr  in  AW  write port 0 address
- wr0_data  in  XLEN  write port 0 data
- wr1_en  in  1  write port 1 enable (higher priority)
- wr1_addr  in  AW  write port 1 address
- wr1_data  in  XLEN  write port 1 data
- bs_en  in  1  busy-set request (instruction issued with destination bs_addr)
- bs_addr  in  AW  register to mark busy
- busy_vec  out  DEPTH  full scoreboard, bit i = register i pending

Behaviour:
- Reset (rst=1, asynchronous, no clock required): all registers = 0, all busy bits = 0. Consequently rd_data = 0, rd_busy = 0, busy_vec = 0 while rst is held. Writes and busy-sets are ignored while rst=1. Deassertion takes effect at the next clk edge.
- Write: on the rising edge, if wrN_en=1 and wrN_addr != 0, then reg[wrN_addr] <= wrN_data. Latency 1 cycle: the stored value is visible from the next cycle.
- x0: writes to address 0 are dropped. Reads of address 0 always return 0, in both BYPASS modes. busy_vec[0] is always 0 and a bs_en to address 0 is ignored.
- Write collision (both enables set, same nonzero address): wr1_data is stored and wr0 is discarded.
- Read: combinational from rd_addr. Out-of-range is impossible because DEPTH = 2^AW.
- Bypass (BYPASS=1): if rd_addr[k] != 0 matches an enabled write address, rd_data[k] returns that write data; wr1 takes precedence over wr0. With BYPASS=0, rd_data[k] returns the pre-edge stored value.
- Scoreboard, evaluated per register i on each edge:
  - set = bs_en && bs_addr==i && i!=0
  - clr = (wr0_en && wr0_addr==i) || (wr1_en && wr1_addr==i)
  - set takes priority: set=1 gives busy[i] <= 1; otherwise clr=1 gives busy[i] <= 0; otherwise hold.
  - Set and clear of the same register in the same cycle leaves busy=1, because a new producer has been issued.
- rd_busy[k] = busy[rd_addr[k]], combinational. When BYPASS=1 and a same-cycle write clears that register (and no set targets it), rd_busy[k] reads 0 in that cycle. With BYPASS=0 it shows the registered busy value.
- Reset mid-operation: in-flight writes and sets in the reset cycle are lost. Registers and scoreboard are zero immediately.
- No X propagation: every output is defined from reset onward.

Test Plan:
1. Assert rst, then release. Read all 32 addresses on both ports: every rd_data=0, busy_vec=0.
2. wr0 writes x5=0xDEADBEEF. rd_addr0=5 with BYPASS=1: 0xDEADBEEF in the same cycle. With BYPASS=0: 0 in the same cycle, 0xDEADBEEF the next cycle.
3. wr0 and wr1 both write 0x12345678 to x0: a read of x0 returns 0. Then wr0=0x11 and wr1=0x22 both to x7 in one cycle: x7 reads 0x22.
4. bs_en to x9: busy_vec[9]=1 and rd_busy for a port on x9 =1. Write x9=0x55: busy clears and the data reads 0x55. Then bs_en x9 and wr1 x9 in the same cycle: busy_vec[9] stays 1.
5. Write x3=0xA5A5A5A5 and set busy x3, then pulse rst between clock edges: x3 reads 0 and busy_vec=0 immediately, without waiting for an edge.
6. NRD=4, XLEN=64, DEPTH=16 build: four ports read x1..x4 after distinct 64-bit writes, and each port returns the correct value.
